saes64_ks_sequencer: RTL and testbench

- Initiator for one riscv_crypto_fu_saes64 instance. Drives the FU's valid/ready and operand interface to run a full AES-128 encrypt key expansion using only saes64.ks1 and saes64.ks2.
- Accepts a 128-bit cipher key and streams round keys 0..10 through a valid/ready output port.
- Sits between key-load logic and the round-key store in the AES64 datapath.

---
 rtl/saes64_ks_sequencer.sv | 146 ++++++++++++++
 tb/tb_saes64_ks_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saes64_ks_sequencer.sv
// AES-128 encrypt key-expansion sequencer driving one saes64 FU with ks1/ks2 only.
// Streams round keys 0..NROUNDS as {k1,k0} through a valid/ready port.
module saes64_ks_sequencer #(
    parameter int NROUNDS = 10
) (
    input  logic         g_clk,
    input  logic         g_reset,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    output logic         fu_valid,
    input  logic         fu_ready,
    input  logic [63:0]  fu_rd,
    output logic [63:0]  fu_rs1,
    output logic [63:0]  fu_rs2,
    output logic [3:0]   fu_enc_rcon,
    output logic         fu_op_ks1,
    output logic         fu_op_ks2
);

    // state | meaning
    // IDLE  | waiting for start
    // EMIT  | presenting {k1,k0} as round key `round`
    // KS1   | t  = ks1(k1, round)
    // KS2LO | k0 = ks2(t, k0)
    // KS2HI | k1 = ks2(k0, k1), round + 1
    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_KS1,
        S_KS2LO,
        S_KS2HI
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

    state_t      state;
    logic [63:0] k0;
    logic [63:0] k1;
    logic [63:0] t;
    logic [3:0]  round;

    // Each FU state spends its first cycle with fu_valid low while the operands
    // are loaded; that cycle is also the mandatory gap after the prior handshake.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state       <= S_IDLE;
            k0          <= '0;
            k1          <= '0;
            t           <= '0;
            round       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rk_valid    <= 1'b0;
            rk_data     <= '0;
            rk_index    <= '0;
            fu_valid    <= 1'b0;
            fu_rs1      <= '0;
            fu_rs2      <= '0;
            fu_enc_rcon <= '0;
            fu_op_ks1   <= 1'b0;
            fu_op_ks2   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k0       <= key[63:0];
                        k1       <= key[127:64];
                        round    <= '0;
                        busy     <= 1'b1;
                        rk_valid <= 1'b1;
                        rk_data  <= key;
                        rk_index <= '0;
                        state    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (rk_ready) begin
                        rk_valid <= 1'b0;
                        if (round == LAST_ROUND) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            state <= S_KS1;
                        end
                    end
                end
                S_KS1: begin
                    if (!fu_valid) begin
                        fu_valid    <= 1'b1;
                        fu_op_ks1   <= 1'b1;
                        fu_rs1      <= k1;
                        fu_rs2      <= '0;
                        fu_enc_rcon <= round;
                    end else if (fu_ready) begin
                        t         <= fu_rd;
                        fu_valid  <= 1'b0;
                        fu_op_ks1 <= 1'b0;
                        state     <= S_KS2LO;
                    end
                end
                S_KS2LO: begin
                    if (!fu_valid) begin
                        fu_valid  <= 1'b1;
                        fu_op_ks2 <= 1'b1;
                        fu_rs1    <= t;
                        fu_rs2    <= k0;
                    end else if (fu_ready) begin
                        k0        <= fu_rd;
                        fu_valid  <= 1'b0;
                        fu_op_ks2 <= 1'b0;
                        state     <= S_KS2HI;
                    end
                end
                S_KS2HI: begin
                    if (!fu_valid) begin
                        fu_valid  <= 1'b1;
                        fu_op_ks2 <= 1'b1;
                        fu_rs1    <= k0;
                        fu_rs2    <= k1;
                    end else if (fu_ready) begin
                        k1        <= fu_rd;
                        round     <= round + 4'd1;
                        fu_valid  <= 1'b0;
                        fu_op_ks2 <= 1'b0;
                        rk_valid  <= 1'b1;
                        rk_data   <= {fu_rd, k0};
                        rk_index  <= round + 4'd1;
                        state     <= S_EMIT;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_saes64_ks_sequencer.sv
// Directed bench for saes64_ks_sequencer with a behavioural saes64 ks1/ks2 FU model
// and a protocol monitor; expected round keys are the published FIPS-197 values.
module tb_saes64_ks_sequencer;

    logic         g_clk = 1'b0;
    logic         g_reset;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_index;
    logic         fu_valid;
    logic         fu_ready;
    logic [63:0]  fu_rd;
    logic [63:0]  fu_rs1;
    logic [63:0]  fu_rs2;
    logic [3:0]   fu_enc_rcon;
    logic         fu_op_ks1;
    logic         fu_op_ks2;

    saes64_ks_sequencer #(.NROUNDS(10)) dut (
        .g_clk       (g_clk),
        .g_reset     (g_reset),
        .start       (start),
        .key         (key),
        .busy        (busy),
        .done        (done),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_data     (rk_data),
        .rk_index    (rk_index),
        .fu_valid    (fu_valid),
        .fu_ready    (fu_ready),
        .fu_rd       (fu_rd),
        .fu_rs1      (fu_rs1),
        .fu_rs2      (fu_rs2),
        .fu_enc_rcon (fu_enc_rcon),
        .fu_op_ks1   (fu_op_ks1),
        .fu_op_ks2   (fu_op_ks2)
    );

    always #5 g_clk = ~g_clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge g_clk) cyc++;

    // ---------------- FU reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [63:0] fu_ks1(input logic [63:0] rs1, input logic [3:0] rnum);
        logic [31:0] w;
        logic [31:0] s;
        logic [7:0]  rc;
        w = rs1[63:32];
        if (rnum != 4'ha) w = {w[7:0], w[31:8]};
        for (int i = 0; i < 4; i++) s[8*i +: 8] = sbox(w[8*i +: 8]);
        rc = 8'h01;
        for (int i = 0; i < 10; i++) if (i < int'(rnum)) rc = xtime(rc);
        if (rnum == 4'ha) rc = 8'h00;
        s = s ^ {24'h0, rc};
        return {s, s};
    endfunction

    function automatic logic [63:0] fu_ks2(input logic [63:0] rs1, input logic [63:0] rs2);
        logic [31:0] w0;
        logic [31:0] w1;
        w0 = rs1[63:32] ^ rs2[31:0];
        w1 = w0 ^ rs2[63:32];
        return {w1, w0};
    endfunction

    assign fu_rd = fu_op_ks1 ? fu_ks1(fu_rs1, fu_enc_rcon) :
                   (fu_op_ks2 ? fu_ks2(fu_rs1, fu_rs2) : 64'h0);

    int fu_wait_max = 0;
    int fu_wait = 0;

    // Ready is driven just after the edge so a zero-wait FU answers in the first valid cycle.
    always @(posedge g_clk) begin
        #1;
        if (fu_valid) begin
            if (fu_wait == 0) fu_ready = 1'b1;
            else begin
                fu_ready = 1'b0;
                fu_wait--;
            end
        end else begin
            fu_ready = (fu_wait_max != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            fu_wait  = (fu_wait_max != 0) ? int'($urandom_range(0, fu_wait_max)) : 0;
        end
    end

    // ---------------- expected values ----------------
    function automatic logic [127:0] bswap(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
        return r;
    endfunction

    function automatic logic [127:0] fips_rk(input int n);
        logic [127:0] v;
        case (n)
            0:  v = 128'h2b7e151628aed2a6abf7158809cf4f3c;
            1:  v = 128'ha0fafe1788542cb123a339392a6c7605;
            2:  v = 128'hf2c295f27a96b9435935807a7359f67f;
            3:  v = 128'h3d80477d4716fe3e1e237e446d7a883b;
            4:  v = 128'hef44a541a8525b7fb671253bdb0bad00;
            5:  v = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            6:  v = 128'h6d88a37a110b3efddbf98641ca0093fd;
            7:  v = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            8:  v = 128'head27321b58dbad2312bf5607f8d292f;
            9:  v = 128'hac7766f319fadc2128d12941575c006e;
            10: v = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            default: v = '0;
        endcase
        return bswap(v);
    endfunction

    // ---------------- monitor ----------------
    logic [127:0] rk_q[$];
    logic [3:0]   idx_q[$];
    int           rk_cyc_q[$];
    int           done_cnt = 0;
    int           done_cyc = -1;
    int           proto_viol = 0;
    int           stall3_cnt = 0;
    int           fv_cnt = 0;
    int           chk_req = 0;
    logic         ks2_par = 1'b0;
    logic         p_fv = 1'b0, p_hs = 1'b0, p_rv = 1'b0, p_rhs = 1'b0;
    logic         p_k1, p_k2;
    logic [63:0]  p_rs1, p_rs2;
    logic [3:0]   p_rc, p_ri;
    logic [127:0] p_rd;
    logic         hs, rhs;

    always @(negedge g_clk) begin
        if (g_reset) begin
            p_fv = 1'b0; p_hs = 1'b0; p_rv = 1'b0; p_rhs = 1'b0;
            chk_req = 0; ks2_par = 1'b0;
        end else begin
            hs  = fu_valid && fu_ready;
            rhs = rk_valid && rk_ready;
            if (p_fv && !p_hs && (!fu_valid || fu_rs1 !== p_rs1 || fu_rs2 !== p_rs2 ||
                fu_enc_rcon !== p_rc || fu_op_ks1 !== p_k1 || fu_op_ks2 !== p_k2))
                proto_viol++;
            if (p_hs && fu_valid) proto_viol++;
            if (chk_req != 0) begin
                chk_req--;
                if (chk_req == 0 && !fu_valid) proto_viol++;
            end
            if (fu_valid && (fu_op_ks1 == fu_op_ks2)) proto_viol++;
            if (!fu_valid && (fu_op_ks1 || fu_op_ks2)) proto_viol++;
            if (fu_valid && fu_op_ks1 && fu_enc_rcon > 4'd9) proto_viol++;
            if (rk_valid && fu_valid) proto_viol++;
            if (p_rv && !p_rhs && (!rk_valid || rk_data !== p_rd || rk_index !== p_ri))
                proto_viol++;
            if (hs && (fu_op_ks1 || (fu_op_ks2 && !ks2_par))) chk_req = 2;
            if (hs && fu_op_ks2) ks2_par = ~ks2_par;
            if (rk_valid && !p_rv) rk_cyc_q.push_back(cyc);
            if (rhs) begin
                rk_q.push_back(rk_data);
                idx_q.push_back(rk_index);
            end
            if (rk_valid && !rk_ready && rk_index == 4'd3) stall3_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (fu_valid) fv_cnt++;
            p_fv = fu_valid; p_hs = hs; p_rv = rk_valid; p_rhs = rhs;
            p_rs1 = fu_rs1; p_rs2 = fu_rs2; p_rc = fu_enc_rcon;
            p_k1 = fu_op_ks1; p_k2 = fu_op_ks2; p_rd = rk_data; p_ri = rk_index;
        end
    end

    // ---------------- helpers ----------------
    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rk_q.delete();
        idx_q.delete();
        rk_cyc_q.delete();
        done_cnt = 0;
        done_cyc = -1;
        proto_viol = 0;
        stall3_cnt = 0;
    endtask

    task automatic do_reset();
        g_reset = 1'b1;
        repeat (2) @(posedge g_clk);
        #1 g_reset = 1'b0;
        clear_logs();
    endtask

    // Called at posedge+1; t_edge is the cycle number of the edge that samples start.
    task automatic pulse_start(input logic [127:0] k, output int t_edge);
        key = k;
        start = 1'b1;
        t_edge = cyc + 1;
        @(posedge g_clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k = 0;
        while (done_cnt == 0 && k < limit) begin
            @(posedge g_clk);
            #1;
            k++;
        end
        check_val({tag, "_done_seen"}, 128'(done_cnt > 0), 128'd1);
    endtask

    // Timing: rk_n first visible in cycle t0+7n, done pulse in cycle t0+71 (+ stalls).
    task automatic check_fips_seq(input string tag, input int t0, input int extra);
        int c0, c1;
        check_val({tag, "_count"}, 128'(rk_q.size()), 128'd11);
        for (int n = 0; n < 11; n++) begin
            if (n < rk_q.size()) begin
                check_val($sformatf("%s_rk%0d", tag, n), rk_q[n], fips_rk(n));
                check_val($sformatf("%s_idx%0d", tag, n), 128'(idx_q[n]), 128'(n));
            end
        end
        check_val({tag, "_done_cnt"}, 128'(done_cnt), 128'd1);
        if (extra >= 0) begin
            c0 = (rk_cyc_q.size() > 0) ? rk_cyc_q[0] : -1;
            c1 = (rk_cyc_q.size() > 1) ? rk_cyc_q[1] : -1;
            check_val({tag, "_rk0_cyc"}, 128'(c0), 128'(t0));
            check_val({tag, "_rk1_cyc"}, 128'(c1), 128'(t0 + 7));
            check_val({tag, "_done_cyc"}, 128'(done_cyc), 128'(t0 + 71 + extra));
        end
        check_val({tag, "_proto"}, 128'(proto_viol), 128'd0);
    endtask

    localparam logic [127:0] FIPS_KEY_BE = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ALT_KEY     = 128'h00112233445566778899aabbccddeeff;

    initial begin
        int t0, tdummy, k, fv_snap, rk_snap;
        g_reset = 1'b1;
        start = 1'b0;
        key = '0;
        rk_ready = 1'b1;
        fu_ready = 1'b0;

        // reset state
        do_reset();
        @(negedge g_clk);
        check_val("rst_busy",     128'(busy),        128'd0);
        check_val("rst_done",     128'(done),        128'd0);
        check_val("rst_rk_valid", 128'(rk_valid),    128'd0);
        check_val("rst_fu_valid", 128'(fu_valid),    128'd0);
        check_val("rst_ops",      128'({fu_op_ks1, fu_op_ks2}), 128'd0);
        check_val("rst_rk_data",  rk_data,           128'd0);
        check_val("rst_rk_index", 128'(rk_index),    128'd0);
        check_val("rst_fu_rs",    {fu_rs1, fu_rs2},  128'd0);
        check_val("rst_rcon",     128'(fu_enc_rcon), 128'd0);
        @(posedge g_clk);
        #1;

        // FIPS key, zero-wait FU, consumer always ready
        fu_wait_max = 0;
        clear_logs();
        pulse_start(bswap(FIPS_KEY_BE), t0);
        wait_done("fips", 150);
        check_fips_seq("fips", t0, 0);

        // random FU stalls
        do_reset();
        fu_wait_max = 3;
        pulse_start(bswap(FIPS_KEY_BE), t0);
        wait_done("fustall", 600);
        check_fips_seq("fustall", t0, -1);
        fu_wait_max = 0;

        // consumer stall on rk3
        do_reset();
        pulse_start(bswap(FIPS_KEY_BE), t0);
        k = 0;
        while (!(rk_valid && rk_index == 4'd3) && k < 100) begin
            @(posedge g_clk);
            #1;
            k++;
        end
        rk_ready = 1'b0;
        fv_snap = fv_cnt;
        repeat (5) begin
            @(posedge g_clk);
            #1;
        end
        check_val("stall_no_fu", 128'(fv_cnt - fv_snap), 128'd0);
        rk_ready = 1'b1;
        wait_done("stall", 150);
        check_val("stall_rk3_cycles", 128'(stall3_cnt), 128'd5);
        check_fips_seq("stall", t0, 5);

        // start during round 4 is ignored
        do_reset();
        pulse_start(bswap(FIPS_KEY_BE), t0);
        k = 0;
        while (!(rk_valid && rk_index == 4'd4) && k < 100) begin
            @(posedge g_clk);
            #1;
            k++;
        end
        repeat (2) begin
            @(posedge g_clk);
            #1;
        end
        pulse_start(ALT_KEY, tdummy);
        wait_done("ignstart", 150);
        check_fips_seq("ignstart", t0, 0);
        repeat (10) begin
            @(posedge g_clk);
            #1;
        end
        check_val("ignstart_idle", 128'(busy), 128'd0);
        check_val("ignstart_no_more_rk", 128'(rk_q.size()), 128'd11);

        // reset while in KS2LO
        do_reset();
        pulse_start(ALT_KEY, tdummy);
        k = 0;
        while (!(fu_valid && fu_op_ks1) && k < 100) begin
            @(posedge g_clk);
            #1;
            k++;
        end
        while (!(fu_valid && fu_op_ks2) && k < 100) begin
            @(posedge g_clk);
            #1;
            k++;
        end
        g_reset = 1'b1;
        @(posedge g_clk);
        #1 g_reset = 1'b0;
        clear_logs();
        @(negedge g_clk);
        check_val("abort_busy",     128'(busy),     128'd0);
        check_val("abort_fu_valid", 128'(fu_valid), 128'd0);
        check_val("abort_rk_valid", 128'(rk_valid), 128'd0);
        fv_snap = fv_cnt;
        rk_snap = rk_q.size();
        repeat (8) @(posedge g_clk);
        #1;
        check_val("abort_quiet_fu", 128'(fv_cnt - fv_snap), 128'd0);
        check_val("abort_quiet_rk", 128'(rk_q.size() - rk_snap), 128'd0);
        pulse_start(bswap(FIPS_KEY_BE), t0);
        wait_done("after_abort", 150);
        check_fips_seq("after_abort", t0, 0);

        // all-zero key
        do_reset();
        pulse_start(128'h0, t0);
        wait_done("zero", 150);
        check_val("zero_count", 128'(rk_q.size()), 128'd11);
        if (rk_q.size() == 11) begin
            check_val("zero_rk0",  rk_q[0],  128'h0);
            check_val("zero_rk1",  rk_q[1],  bswap(128'h62636363626363636263636362636363));
            check_val("zero_rk10", rk_q[10], bswap(128'hb4ef5bcb3e92e21123e951cf6f8f188e));
            check_val("zero_idx10", 128'(idx_q[10]), 128'd10);
        end
        check_val("zero_done_cyc", 128'(done_cyc), 128'(t0 + 71));
        check_val("zero_proto", 128'(proto_viol), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not complete, got time %0t expected < 300000", $time);
        $fatal(1);
    end

endmodule
